// File: rtl/id_ctrl_pipe.sv
// rtl/id_ctrl_pipe.sv - ID decode, control pipeline and hazard unit (optional jal via CTRL_JAL_EN)
module id_ctrl_pipe #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  input  logic [5:0]       op_i,
  input  logic [RA_W-1:0]  rs_i,
  input  logic [RA_W-1:0]  rt_i,
  input  logic [RA_W-1:0]  rd_i,
  input  logic             taken_i,
  output logic             stall_o,
  output logic             flush_o,
  output logic             id_branch_o,
  output logic             id_jump_o,
  output logic             ex_reg_dst_o,
  output logic             ex_alu_src_o,
  output logic [2:0]       ex_alu_op_o,
  output logic             ex_link_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             wb_reg_write_o,
  output logic             wb_mem_to_reg_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic            regDst, aluSrc, regWrite, memRead, memWrite, memToReg;
  logic            branch, jump, usesRt, illegalOp;
  logic [2:0]      aluOp;
  logic [RA_W-1:0] idDst;
`ifdef CTRL_JAL_EN
  logic            link, exLink;
`endif

  logic            exRegDst, exAluSrc, exRegWrite, exMemRead, exMemWrite, exMemToReg;
  logic [2:0]      exAluOp;
  logic [RA_W-1:0] exDst;
  logic            memMemRead, memMemWrite, memRegWrite, memMemToReg;
  logic [RA_W-1:0] memDst;
  logic            wbRegWrite, wbMemToReg;
  logic            loadUse, branchHaz;
  logic            illegalQ;
  logic [CNT_W-1:0] stallCnt;

  // A producer only matters when it writes a real register (r0 is never a dependency)
  function automatic logic srcMatch(input logic [RA_W-1:0] dst, input logic [RA_W-1:0] src);
    return (dst == src) && (dst != '0);
  endfunction

  // Main decoder; an empty IF/ID slot decodes as all-zero
  always_comb begin
    regDst    = 1'b0;
    aluSrc    = 1'b0;
    aluOp     = 3'b000;
    regWrite  = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    memToReg  = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    usesRt    = 1'b0;
    illegalOp = 1'b0;
`ifdef CTRL_JAL_EN
    link      = 1'b0;
`endif
    if (valid_i) begin
      case (op_i)
        6'b000000: begin regDst = 1'b1; aluOp = 3'b010; regWrite = 1'b1; usesRt = 1'b1; end
        6'b001000: begin aluSrc = 1'b1; regWrite = 1'b1; end
        6'b001100: begin aluOp = 3'b011; aluSrc = 1'b1; regWrite = 1'b1; end
        6'b001101: begin aluOp = 3'b100; aluSrc = 1'b1; regWrite = 1'b1; end
        6'b001010: begin aluOp = 3'b101; aluSrc = 1'b1; regWrite = 1'b1; end
        6'b100011: begin aluSrc = 1'b1; regWrite = 1'b1; memRead = 1'b1; memToReg = 1'b1; end
        6'b101011: begin aluSrc = 1'b1; memWrite = 1'b1; usesRt = 1'b1; end
        6'b000100,
        6'b000101: begin aluOp = 3'b001; branch = 1'b1; usesRt = 1'b1; end
        6'b000010: jump = 1'b1;
`ifdef CTRL_JAL_EN
        6'b000011: begin jump = 1'b1; regWrite = 1'b1; link = 1'b1; end
`endif
        default:   illegalOp = 1'b1;
      endcase
    end
  end

`ifdef CTRL_JAL_EN
  assign idDst     = link ? RA_W'(31) : (regDst ? rd_i : rt_i);
  assign ex_link_o = exLink;
`else
  assign idDst     = regDst ? rd_i : rt_i;
  assign ex_link_o = 1'b0;
`endif

  // Hazard detection: loads stall consumers one cycle; branches resolve in ID so they also wait on EX ALU results and MEM loads
  always_comb begin
    loadUse   = valid_i & exMemRead &
                (srcMatch(exDst, rs_i) | (usesRt & srcMatch(exDst, rt_i)));
    branchHaz = branch &
                ((exRegWrite & (srcMatch(exDst, rs_i) | srcMatch(exDst, rt_i))) |
                 (memMemRead & (srcMatch(memDst, rs_i) | srcMatch(memDst, rt_i))));
  end

  assign stall_o     = loadUse | branchHaz;
  assign flush_o     = valid_i & ~stall_o & (jump | (branch & taken_i));
  assign id_branch_o = branch;
  assign id_jump_o   = jump;

  // ID/EX register: inserts a bubble while the ID instruction is held
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      exRegDst <= 1'b0; exAluSrc <= 1'b0; exAluOp <= 3'b000; exRegWrite <= 1'b0;
      exMemRead <= 1'b0; exMemWrite <= 1'b0; exMemToReg <= 1'b0; exDst <= '0;
`ifdef CTRL_JAL_EN
      exLink <= 1'b0;
`endif
    end else if (stall_o) begin
      exRegDst <= 1'b0; exAluSrc <= 1'b0; exAluOp <= 3'b000; exRegWrite <= 1'b0;
      exMemRead <= 1'b0; exMemWrite <= 1'b0; exMemToReg <= 1'b0; exDst <= '0;
`ifdef CTRL_JAL_EN
      exLink <= 1'b0;
`endif
    end else begin
      exRegDst <= regDst; exAluSrc <= aluSrc; exAluOp <= aluOp; exRegWrite <= regWrite;
      exMemRead <= memRead; exMemWrite <= memWrite; exMemToReg <= memToReg; exDst <= idDst;
`ifdef CTRL_JAL_EN
      exLink <= link;
`endif
    end
  end

  // EX/MEM and MEM/WB registers always advance
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      memMemRead <= 1'b0; memMemWrite <= 1'b0; memRegWrite <= 1'b0; memMemToReg <= 1'b0;
      memDst <= '0; wbRegWrite <= 1'b0; wbMemToReg <= 1'b0;
    end else begin
      memMemRead <= exMemRead; memMemWrite <= exMemWrite; memRegWrite <= exRegWrite;
      memMemToReg <= exMemToReg; memDst <= exDst;
      wbRegWrite <= memRegWrite; wbMemToReg <= memMemToReg;
    end
  end

  // Sticky illegal flag and saturating stall counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      illegalQ <= 1'b0;
      stallCnt <= '0;
    end else begin
      if (illegalOp) illegalQ <= 1'b1;
      if (stall_o && (stallCnt != '1)) stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign mem_read_o      = memMemRead;
  assign mem_write_o     = memMemWrite;
  assign wb_reg_write_o  = wbRegWrite;
  assign wb_mem_to_reg_o = wbMemToReg;
  assign ex_reg_dst_o    = exRegDst;
  assign ex_alu_src_o    = exAluSrc;
  assign ex_alu_op_o     = exAluOp;
  assign illegal_o       = illegalQ;
  assign stall_cnt_o     = stallCnt;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// tb/tb_id_ctrl_pipe.sv - scoreboard bench for id_ctrl_pipe
module tb_id_ctrl_pipe;

`ifdef CTRL_JAL_EN
  localparam bit JalEn = 1'b1;
`else
  localparam bit JalEn = 1'b0;
`endif

  localparam logic [5:0] OpR = 6'b000000, OpAddi = 6'b001000, OpAndi = 6'b001100,
                         OpOri = 6'b001101, OpSlti = 6'b001010, OpLw = 6'b100011,
                         OpSw = 6'b101011, OpBeq = 6'b000100, OpBne = 6'b000101,
                         OpJ = 6'b000010, OpJal = 6'b000011, OpBad = 6'b111111;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [5:0]  op_i = '0;
  logic [4:0]  rs_i = '0, rt_i = '0, rd_i = '0;
  logic        taken_i = 1'b0;
  logic        stall_o, flush_o, id_branch_o, id_jump_o;
  logic        ex_reg_dst_o, ex_alu_src_o, ex_link_o;
  logic [2:0]  ex_alu_op_o;
  logic        mem_read_o, mem_write_o, wb_reg_write_o, wb_mem_to_reg_o, illegal_o;
  logic [15:0] stall_cnt_o;

  id_ctrl_pipe #(.RA_W(5), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .op_i(op_i),
    .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .taken_i(taken_i),
    .stall_o(stall_o), .flush_o(flush_o), .id_branch_o(id_branch_o), .id_jump_o(id_jump_o),
    .ex_reg_dst_o(ex_reg_dst_o), .ex_alu_src_o(ex_alu_src_o), .ex_alu_op_o(ex_alu_op_o),
    .ex_link_o(ex_link_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .wb_reg_write_o(wb_reg_write_o), .wb_mem_to_reg_o(wb_mem_to_reg_o),
    .illegal_o(illegal_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int nChecks = 0;
  int nPass = 0;
  int expStallCnt = 0;
  bit expIllegal = 1'b0;
  // entry = {regDst, aluSrc, aluOp[2:0], link, memRead, memWrite, regWrite, memToReg}
  logic [9:0] sbQ[$];

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference decode: {ctrl[9:0], branch, jump, illegal}
  function automatic logic [12:0] refDecode(input logic [5:0] op);
    case (op)
      OpR:          return {10'b1_0_010_0_0_0_1_0, 3'b000};
      OpAddi:       return {10'b0_1_000_0_0_0_1_0, 3'b000};
      OpAndi:       return {10'b0_1_011_0_0_0_1_0, 3'b000};
      OpOri:        return {10'b0_1_100_0_0_0_1_0, 3'b000};
      OpSlti:       return {10'b0_1_101_0_0_0_1_0, 3'b000};
      OpLw:         return {10'b0_1_000_0_1_0_1_1, 3'b000};
      OpSw:         return {10'b0_1_000_0_0_1_0_0, 3'b000};
      OpBeq, OpBne: return {10'b0_0_001_0_0_0_0_0, 3'b100};
      OpJ:          return {10'b0_0_000_0_0_0_0_0, 3'b010};
      OpJal:        return JalEn ? {10'b0_0_000_1_0_0_1_0, 3'b010} : 13'b1;
      default:      return 13'b1;
    endcase
  endfunction

  task automatic runStep(input bit v, input logic [5:0] op, input int rs, input int rt,
                         input int rd, input bit tk, input bit expStall, input bit expFlush);
    logic [12:0] d;
    logic [9:0]  entry;
    @(negedge clk_i);
    valid_i = v; op_i = op; rs_i = 5'(rs); rt_i = 5'(rt); rd_i = 5'(rd); taken_i = tk;
    #1;
    d = v ? refDecode(op) : 13'b0;
    checkEq("stall", 32'(stall_o), 32'(expStall));
    checkEq("flush", 32'(flush_o), 32'(expFlush));
    checkEq("idBranch", 32'(id_branch_o), 32'(d[2]));
    checkEq("idJump", 32'(id_jump_o), 32'(d[1]));
    entry = expStall ? 10'b0 : d[12:3];
    sbQ.push_back(entry);
    if (expStall) expStallCnt++;
    if (d[0]) expIllegal = 1'b1;
    @(posedge clk_i);
    #1;
    void'(sbQ.pop_front());
    checkEq("wbCtrl", 32'({wb_reg_write_o, wb_mem_to_reg_o}), 32'(sbQ[0][1:0]));
    checkEq("memCtrl", 32'({mem_read_o, mem_write_o}), 32'(sbQ[1][3:2]));
    checkEq("exCtrl", 32'({ex_reg_dst_o, ex_alu_src_o, ex_alu_op_o, ex_link_o}), 32'(sbQ[2][9:4]));
    checkEq("stallCnt", 32'(stall_cnt_o), 32'(expStallCnt));
    checkEq("illegal", 32'(illegal_o), 32'(expIllegal));
  endtask

  initial begin
    repeat (3) sbQ.push_back(10'b0);
    repeat (2) @(posedge clk_i);
    #1;
    checkEq("rstEx", 32'({ex_reg_dst_o, ex_alu_src_o, ex_alu_op_o, ex_link_o}), 32'(0));
    checkEq("rstMemWb", 32'({mem_read_o, mem_write_o, wb_reg_write_o, wb_mem_to_reg_o}), 32'(0));
    checkEq("rstCnt", 32'(stall_cnt_o), 32'(0));
    checkEq("rstIllegal", 32'(illegal_o), 32'(0));
    @(negedge clk_i);
    rst_n_i = 1'b1;

    //      v  op      rs  rt  rd  tk stall flush
    runStep(1, OpR,     1,  2,  3, 0, 0, 0);
    runStep(0, OpR,     0,  0,  0, 0, 0, 0);
    runStep(0, OpR,     0,  0,  0, 0, 0, 0);
    runStep(1, OpLw,    1,  4,  0, 0, 0, 0);
    runStep(1, OpR,     4,  6,  7, 0, 1, 0);
    runStep(1, OpR,     4,  6,  7, 0, 0, 0);
    runStep(1, OpAddi,  0,  5,  0, 0, 0, 0);
    runStep(1, OpBeq,   5,  0,  0, 1, 1, 0);
    runStep(1, OpBeq,   5,  0,  0, 1, 0, 1);
    runStep(1, OpLw,    0,  5,  0, 0, 0, 0);
    runStep(1, OpBne,   0,  5,  0, 0, 1, 0);
    runStep(1, OpBne,   0,  5,  0, 0, 1, 0);
    runStep(1, OpBne,   0,  5,  0, 0, 0, 0);
    runStep(1, OpBeq,   0,  0,  0, 1, 0, 1);
    runStep(1, OpJ,     0,  0,  0, 0, 0, 1);
    runStep(1, OpSw,    1,  2,  0, 0, 0, 0);
    runStep(1, OpAndi,  0,  8,  0, 0, 0, 0);
    runStep(1, OpOri,   0,  9,  0, 0, 0, 0);
    runStep(1, OpSlti,  0, 10,  0, 0, 0, 0);
    runStep(1, OpLw,    0,  0,  0, 0, 0, 0);
    runStep(1, OpR,     0,  0,  0, 0, 0, 0);
    runStep(1, OpJal,   0,  0,  0, 0, 0, JalEn);
    runStep(1, OpBeq,  31,  0,  0, 0, JalEn, 0);
    runStep(1, OpBeq,  31,  0,  0, 0, 0, 0);
    runStep(0, OpBeq,  31,  0,  0, 1, 0, 0);
    runStep(0, OpBad,   0,  0,  0, 0, 0, 0);
    runStep(1, OpBad,   0,  0,  0, 0, 0, 0);
    runStep(0, OpR,     0,  0,  0, 0, 0, 0);
    runStep(1, OpLw,    0,  4,  0, 0, 0, 0);

    // Reset asserted while a load-use stall is active
    @(negedge clk_i);
    valid_i = 1'b1; op_i = OpR; rs_i = 5'd4; rt_i = 5'd6; rd_i = 5'd7; taken_i = 1'b0;
    #1;
    checkEq("midStall", 32'(stall_o), 32'(1));
    rst_n_i = 1'b0;
    #1;
    checkEq("rstStall", 32'(stall_o), 32'(0));
    checkEq("rstExSrc", 32'(ex_alu_src_o), 32'(0));
    checkEq("rstMemRd", 32'(mem_read_o), 32'(0));
    checkEq("rstCnt2", 32'(stall_cnt_o), 32'(0));
    checkEq("rstIll2", 32'(illegal_o), 32'(0));
    @(negedge clk_i);
    rst_n_i = 1'b1;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/id_ctrl_pipe.md
# id_ctrl_pipe

Parametrised decode-and-control pipeline for the 5-stage MIPS datapath; successor to the single-cycle main decoder. Decodes the ID-stage opcode, carries control bits through the ID/EX, EX/MEM and MEM/WB registers, and detects load-use and branch-operand hazards. Drives stall/flush to the IF/ID register and PC and keeps a saturating stall counter. Sits between the IF/ID register and the datapath muxes.

## Interface
Parameters:
- RA_W, 5, register-address width.
- CNT_W, 16, stall-counter width.

Ports:
- clk_i  in  1  rising-edge clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- valid_i  in  1  IF/ID holds a real instruction.
- op_i  in  6  instruction[31:26].
- rs_i, rt_i, rd_i  in  RA_W  ID register fields.
- taken_i  in  1  ID comparator result; rs==rt for beq, rs!=rt for bne.
- stall_o  out  1  hold PC and IF/ID; combinational.
- flush_o  out  1  squash IF/ID; combinational.
- id_branch_o, id_jump_o  out  1  ID decode; combinational.
- ex_reg_dst_o, ex_alu_src_o  out  1  EX mux selects.
- ex_alu_op_o  out  3  ALU op class.
- ex_link_o  out  1  write PC+8 to r31.
- mem_read_o, mem_write_o  out  1  MEM stage.
- wb_reg_write_o, wb_mem_to_reg_o  out  1  WB stage.
- illegal_o  out  1  sticky illegal-opcode flag.
- stall_cnt_o  out  CNT_W  saturating stall count.

## Operation
- Decode; fields are RegDst/ALUOp/ALUSrc/RegWrite/MemRead/MemWrite/MemtoReg/Branch/Jump:
  - R 000000: 1/010/0/1/0/0/0/0/0.
  - addi 001000: 0/000/1/1.
  - andi 001100: ALUOp 011, ALUSrc 1, RegWrite 1.
  - ori 001101: ALUOp 100, ALUSrc 1, RegWrite 1.
  - slti 001010: ALUOp 101, ALUSrc 1, RegWrite 1.
  - lw 100011: ALUOp 000, ALUSrc 1, RegWrite 1, MemRead 1, MemtoReg 1.
  - sw 101011: ALUOp 000, ALUSrc 1, MemWrite 1.
  - beq 000100 and bne 000101: ALUOp 001, Branch 1.
  - j 000010: Jump 1.
  - Every field not listed is 0.
- Illegal opcode: all fields 0; sets illegal_o when valid_i=1.
- valid_i=0 decodes as all-zero, with no hazard and no flush.
- Destination register: dst = RegDst ? rd : rt; dst = 31 when link. Tracked in ID/EX and EX/MEM.
- uses_rt = R-type | sw | beq | bne.
- A source matches when dst==src and dst!=0.
- Load-use: EX MemRead=1 and EX dst matches rs, or matches rt with uses_rt.
- Branch hazard: ID Branch=1, and either:
  - EX RegWrite=1 with EX dst matching rs/rt; or
  - MEM MemRead=1 with MEM dst matching rs/rt.
- stall_o = load-use | branch hazard.
- flush_o = valid_i & ~stall_o & (Jump | Branch & taken_i). Stall has priority over flush.
- On stall: ID/EX loads a bubble (all control 0, dst 0). EX/MEM and MEM/WB always advance; there is no back-pressure.
- stall_cnt_o increments on each stall cycle and holds at 2^CNT_W-1.

## Timing
- Reset (async assert, sync release): all ID/EX, EX/MEM and MEM/WB bits are 0, illegal_o=0, stall_cnt_o=0.
- Combinational outputs stall_o, flush_o, id_* are valid in the same cycle as their inputs.
- Latency from ID decode:
  - 1 edge to ex_* outputs.
  - 2 edges to mem_* outputs.
  - 3 edges to wb_* outputs.
- Stall lengths:
  - Load-use: exactly 1 cycle.
  - Branch after an ALU producer: 1 cycle.
  - Branch after lw: 2 cycles (EX, then MEM).
- Reset asserted mid-stall clears all pipeline state at once; stall_o then depends only on ID inputs.
- illegal_o clears only on reset.

## Configuration
- CTRL_JAL_EN defined:
  - Opcode 000011 (jal) decodes with Jump=1, RegWrite=1, link=1 and dst=31.
  - The flush follows the j rule.
  - ex_link_o=1 for jal.
- CTRL_JAL_EN undefined: 000011 is illegal and ex_link_o is tied 0.

## Test plan
- Reset, then R-type rd=3 with valid_i=1 -> after 1 edge, ex_reg_dst_o=1 and ex_alu_op_o=010; after 3 edges, wb_reg_write_o=1.
- lw rt=4, then add rs=4 -> stall_o=1 for one cycle, ID/EX bubble, stall_cnt_o=1; the add reaches EX on the next edge.
- addi rt=5, then beq rs=5 -> 1-cycle stall; lw rt=5, then beq rt=5 -> 2-cycle stall, stall_cnt_o +2.
- beq with taken_i=1 and no hazard -> flush_o=1 and stall_o=0; same with a hazard -> flush_o=0 until the stall clears.
- Opcode 111111 with valid_i=1 -> all controls 0 and illegal_o=1, sticky until rst_n_i=0.
- jal -> with CTRL_JAL_EN: ex_link_o=1, dst=31, flush_o=1; without it: illegal_o=1.
